// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider / tick generator with a shadowed divisor
// that is committed only at period boundaries, restart or reset.
module clk_div_prog #(
    parameter int CNT_W       = 16,
    parameter int DIV_DEFAULT = 50
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             restart,
    input  logic             mode,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic             div_pending
);

    if (DIV_DEFAULT < 2 || longint'(DIV_DEFAULT) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_default
        $error("clk_div_prog: DIV_DEFAULT out of range 2..2^CNT_W-1");
    end

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_act_q, div_act_d;
    logic [CNT_W-1:0] div_shd_q, div_shd_d;
    logic [CNT_W-1:0] div_clamped, half_d, last_d;
    logic             pend_q, pend_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             wrap, boundary;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        cnt_d     = cnt_q;
        div_act_d = div_act_q;
        div_shd_d = div_shd_q;
        pend_d    = pend_q;

        div_clamped = (div_in < DIV_MIN) ? DIV_MIN : div_in;
        wrap        = (cnt_q == div_act_q - ONE);
        boundary    = restart || (enable && wrap);

        if (boundary) begin
            // A load coinciding with a boundary bypasses the shadow entirely.
            cnt_d = '0;
            if (div_load) begin
                div_act_d = div_clamped;
                div_shd_d = div_clamped;
                pend_d    = 1'b0;
            end else if (pend_q) begin
                div_act_d = div_shd_q;
                pend_d    = 1'b0;
            end
        end else begin
            if (enable) begin
                cnt_d = cnt_q + ONE;
            end
            if (div_load) begin
                div_shd_d = div_clamped;
                pend_d    = 1'b1;
            end
        end

        // H = ceil(D/2) without the overflow that D+1 could cause.
        half_d = (div_act_d >> 1) + {{(CNT_W-1){1'b0}}, div_act_d[0]};
        last_d = div_act_d - ONE;
        tick_d = enable && !restart && (cnt_d == last_d);

        if (restart) begin
            clk_out_d = 1'b0;
        end else if (!enable) begin
            clk_out_d = clk_out_q;
        end else if (mode) begin
            clk_out_d = tick_d;
        end else begin
            clk_out_d = (cnt_d >= div_act_d - half_d);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            div_act_q <= DIV_RST;
            div_shd_q <= DIV_RST;
            pend_q    <= 1'b0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_act_q <= div_act_d;
            div_shd_q <= div_shd_d;
            pend_q    <= pend_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out     = clk_out_q;
    assign tick        = tick_q;
    assign div_pending = pend_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed scenarios plus random traffic,
// every cycle compared against a plain-arithmetic reference model.
module tb_clk_div_prog;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        restart = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] div_in = '0;
    logic        div_load = 1'b0;
    logic        clk_out, tick, div_pending;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: phase in period, active/shadow divisor, pending flag.
    int m_cnt = 0, m_d = 50, m_shd = 50;
    bit m_pend = 0, m_clk = 0, m_tick = 0;

    clk_div_prog #(.CNT_W(16), .DIV_DEFAULT(50)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .restart     (restart),
        .mode        (mode),
        .div_in      (div_in),
        .div_load    (div_load),
        .clk_out     (clk_out),
        .tick        (tick),
        .div_pending (div_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic void model(input bit rn, en, rs, ld, md, input int din);
        int dv;
        dv = (din < 2) ? 2 : din;
        if (!rn) begin
            m_cnt = 0; m_d = 50; m_pend = 0; m_clk = 0; m_tick = 0;
        end else if (rs) begin
            m_cnt = 0;
            if (ld) begin m_d = dv; m_pend = 0; end
            else if (m_pend) begin m_d = m_shd; m_pend = 0; end
            m_tick = 0; m_clk = 0;
        end else if (en) begin
            m_cnt = (m_cnt + 1) % m_d;
            if (m_cnt == 0) begin
                if (ld) begin m_d = dv; m_pend = 0; end
                else if (m_pend) begin m_d = m_shd; m_pend = 0; end
            end else if (ld) begin
                m_shd = dv; m_pend = 1;
            end
            m_tick = (m_cnt == m_d - 1);
            m_clk  = md ? m_tick : (m_cnt >= m_d - (m_d + 1) / 2);
        end else begin
            if (ld) begin m_shd = dv; m_pend = 1; end
            m_tick = 0;
        end
    endfunction

    task automatic step(input bit rn, en, rs, ld, input int din);
        rst_n = rn; enable = en; restart = rs; div_load = ld; div_in = din[15:0];
        @(posedge clk);
        model(rn, en, rs, ld, mode, din);
        #1;
        check("clk_out", clk_out, m_clk);
        check("tick", tick, m_tick);
        check("div_pending", div_pending, m_pend);
    endtask

    // Runs enabled cycles until tick is seen; n is the number of edges taken.
    task automatic run_until_tick(output int n);
        n = 0;
        do begin
            step(1, 1, 0, 0, 0);
            n++;
        end while (tick !== 1'b1 && n < 200);
        check("tick_seen", tick, 1);
    endtask

    initial begin
        int n, highs, ticks;
        bit [9:0] pat;

        // Reset default: D=50 square wave.
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("reset_clk_out", clk_out, 0);
        check("reset_pending", div_pending, 0);
        highs = 0; ticks = 0;
        for (int i = 0; i < 200; i++) begin
            step(1, 1, 0, 0, 0);
            highs += int'(clk_out);
            ticks += int'(tick);
            if (i == 24) check("first_high_edge", clk_out, 1);
            if (i == 23) check("last_low_edge", clk_out, 0);
        end
        check("default_tick_count", ticks, 4);
        check("default_high_count", highs, 100);

        // Odd divisor: load 5, restart, expect 0,0,1,1,1 repeating.
        step(1, 1, 0, 1, 5);
        step(1, 1, 1, 0, 0);
        pat[9] = clk_out;
        for (int i = 8; i >= 0; i--) begin
            step(1, 1, 0, 0, 0);
            pat[i] = clk_out;
        end
        check("odd_pattern", {22'd0, pat}, {22'd0, 10'b0011100111});
        mode = 1'b1;
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 0, 0, 0);
            highs += int'(clk_out);
            check("strobe_eq_tick", clk_out, tick);
        end
        check("strobe_count", highs, 2);
        mode = 1'b0;

        // Boundary reload with override by a second load.
        step(1, 1, 1, 1, 50);
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0);
        step(1, 1, 0, 1, 8);
        check("pend_after_load", div_pending, 1);
        for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0);
        step(1, 1, 0, 1, 4);
        run_until_tick(n);
        check("old_period_finish", n, 17);
        check("pend_before_wrap", div_pending, 1);
        run_until_tick(n);
        check("reloaded_period", n, 4);
        check("pend_cleared", div_pending, 0);

        // Load exactly on the wrap edge.
        step(1, 1, 0, 1, 6);
        check("pend_on_wrap", div_pending, 0);
        run_until_tick(n);
        run_until_tick(n);
        check("wrap_load_period", n, 6);

        // Clamp: 0 and 1 both act as 2.
        step(1, 1, 1, 1, 0);
        highs = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 0, 0, 0);
            highs += int'(clk_out);
        end
        check("clamp0_highs", highs, 3);
        step(1, 1, 0, 1, 1);
        run_until_tick(n);
        run_until_tick(n);
        check("clamp1_period", n, 2);

        // Hold mid-period: total enabled edges to the tick is still D-1.
        step(1, 1, 1, 1, 50);
        for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0);
        run_until_tick(n);
        check("hold_total", 20 + n, 49);

        // Restart with a pending load at cnt=30.
        step(1, 1, 1, 1, 50);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
        step(1, 1, 0, 1, 20);
        for (int i = 0; i < 24; i++) step(1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        check("restart_clk_out", clk_out, 0);
        check("restart_pending", div_pending, 0);
        run_until_tick(n);
        check("restart_new_period", n, 19);

        // Reset beats restart and load.
        step(1, 1, 0, 1, 9);
        step(0, 1, 1, 1, 7);
        check("rst_prio_pending", div_pending, 0);
        check("rst_prio_clk_out", clk_out, 0);
        run_until_tick(n);
        check("rst_prio_period", n, 49);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) mode = ~mode;
            step($urandom_range(0, 199) != 0,
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 49) == 0,
                 $urandom_range(0, 19) == 0,
                 int'($urandom_range(0, 12)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
